// File: rtl/addsub_pkg.sv
// addsub_pkg: shared state encoding and default width for the adder-subtractor datapath
package addsub_pkg;
  localparam int DEFAULT_WIDTH = 4;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/full_adder_bit.sv
// full_adder_bit: single-bit full adder cell (a, b, cin -> s, cout)
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial LSB-first add/sub, start/busy/done handshake; ports clk, rst_n, start, sub, a, b -> busy, done, result, cout, overflow
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);
  state_t             state_q;
  logic [WIDTH-1:0]   opa_q, opb_q, res_q, res_d, result_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q, busy_q, done_q, cout_q, ovf_q;
  logic               s, c, accept, last;
  full_adder_bit u_fa (
    .a   (opa_q[0]),
    .b   (opb_q[0]),
    .cin (carry_q),
    .s   (s),
    .cout(c)
  );
  assign accept = start && (state_q != S_SHIFT);
  assign last   = cnt_q == CNT_W'(WIDTH - 1);
  assign res_d  = {s, res_q[WIDTH-1:1]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        opa_q   <= a;
        opb_q   <= b ^ {WIDTH{sub}};
        carry_q <= sub;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
        state_q <= S_SHIFT;
      end else if (state_q == S_SHIFT) begin
        res_q   <= res_d;
        opa_q   <= opa_q >> 1;
        opb_q   <= opb_q >> 1;
        carry_q <= c;
        cnt_q   <= cnt_q + CNT_W'(1);
        if (last) begin
          // carry_q here is the carry into the MSB, c the carry out of it
          result_q <= res_d;
          cout_q   <= c;
          ovf_q    <= carry_q ^ c;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
      end else if (state_q == S_DONE) begin
        state_q <= S_IDLE;
      end
    end
  end
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
endmodule
